// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline sequencing control bundle between the hazard/stall controller
// (slave side) and the pipeline datapath or a test driver (master side).
// dbg_* signals expose the controller FSM state and mult/div counter.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  // Hazard sources from the pipeline
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [4:0]       ex_rt;
  logic             ex_md_start;
  logic             branch_taken;
  logic             mem_access;
  logic             dmem_ready;

  // Register enables / flushes back to the pipeline
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_write;
  logic             idex_flush;
  logic             exmem_write;
  logic             exmem_flush;
  logic             md_busy;
  logic             md_done;
  logic [CNT_W-1:0] stall_cnt;

  // Debug visibility of internal state
  logic             dbg_md_wait;
  logic [7:0]       dbg_md_cnt;

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_md_start,
           branch_taken, mem_access, dmem_ready,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
           exmem_write, exmem_flush, md_busy, md_done, stall_cnt,
           dbg_md_wait, dbg_md_cnt
  );

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_md_start,
           branch_taken, mem_access, dmem_ready,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
           exmem_write, exmem_flush, md_busy, md_done, stall_cnt,
           dbg_md_wait, dbg_md_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core.
// Resolves, by fixed priority: data-memory freeze, taken-branch squash,
// mult/div occupancy of EX, and load-use hazards. Control outputs are
// combinational from FSM state, mult/div counter and inputs, and are forced
// low while rst is asserted. A saturating counter tracks PC-stalled cycles.
// There is no valid/ready handshake here: every input is sampled each cycle
// as a level and every output is a per-cycle level (md_done is a pulse).
module hazard_stall_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  hazard_stall_ctrl_if.slave  bus
);

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  // Counter load value: the start cycle and the release cycle are not
  // counted by the register, so MD_LATENCY-2 wait cycles remain between.
  localparam logic [7:0] MD_INIT = 8'(MD_LATENCY - 2);

  state_t           state_q, state_d;
  logic [7:0]       md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic freeze, load_use, md_start, md_wait, md_release;
  logic pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
  logic exmem_write, exmem_flush, md_busy, md_done;

  assign freeze     = bus.mem_access & ~bus.dmem_ready;
  assign md_start   = (state_q == RUN) & bus.ex_md_start;
  assign md_wait    = (state_q == MD_WAIT) & (md_cnt_q != 8'd0);
  assign md_release = (state_q == MD_WAIT) & (md_cnt_q == 8'd0);
  assign load_use   = bus.ex_mem_read & (bus.ex_rt != 5'd0) &
                      ((bus.ex_rt == bus.id_rs) |
                       (bus.id_uses_rt & (bus.ex_rt == bus.id_rt)));

  // Priority resolution of pipeline controls and FSM/counter next state
  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_write  = 1'b0;
    idex_flush  = 1'b0;
    exmem_write = 1'b0;
    exmem_flush = 1'b0;
    md_busy     = 1'b0;
    md_done     = 1'b0;
    state_d     = state_q;
    md_cnt_d    = md_cnt_q;
    if (!rst) begin
      // everything stays low; registers are held in reset
    end else if (freeze) begin
      // whole pipeline and FSM hold; a pending branch is seen again next cycle
    end else if (bus.branch_taken) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_write  = 1'b1;
      exmem_write = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      state_d     = RUN;
      md_cnt_d    = 8'd0;
    end else if (md_start || md_wait) begin
      exmem_write = 1'b1;
      exmem_flush = 1'b1;
      md_busy     = 1'b1;
      if (md_start) begin
        state_d  = MD_WAIT;
        md_cnt_d = MD_INIT;
      end else begin
        md_cnt_d = md_cnt_q - 8'd1;
      end
    end else begin
      if (md_release) begin
        md_done = 1'b1;
        state_d = RUN;
      end
      if (load_use) begin
        idex_write  = 1'b1;
        idex_flush  = 1'b1;
        exmem_write = 1'b1;
      end else begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        exmem_write = 1'b1;
      end
    end
  end

  // Saturating count of cycles in which the PC does not advance
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (rst && !pc_write && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // State, mult/div counter and stall counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      md_cnt_q    <= 8'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.pc_write    = pc_write;
  assign bus.ifid_write  = ifid_write;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_write  = idex_write;
  assign bus.idex_flush  = idex_flush;
  assign bus.exmem_write = exmem_write;
  assign bus.exmem_flush = exmem_flush;
  assign bus.md_busy     = md_busy;
  assign bus.md_done     = md_done;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.dbg_md_wait = (state_q == MD_WAIT);
  assign bus.dbg_md_cnt  = md_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl. Two instances share stimulus: the
// main one (CNT_W=16) and a narrow-counter one (CNT_W=4) for saturation.
// Expected control vectors are queued as each step is driven and popped
// when the step's outputs are sampled on the falling edge.
module tb_hazard_stall_ctrl;

  // Control vector bit order:
  // {pc, ifid, ifid_flush, idex, idex_flush, exmem, exmem_flush, md_busy, md_done}
  localparam logic [8:0] C_ZERO = 9'b000000000;
  localparam logic [8:0] C_RUN  = 9'b110101000;
  localparam logic [8:0] C_LU   = 9'b000111000;
  localparam logic [8:0] C_MDB  = 9'b000001110;
  localparam logic [8:0] C_REL  = 9'b110101001;
  localparam logic [8:0] C_LUD  = 9'b000111001;
  localparam logic [8:0] C_BR   = 9'b111111000;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  logic [8:0] exp_q[$];

  hazard_stall_ctrl_if #(.CNT_W(16)) bus ();
  hazard_stall_ctrl_if #(.CNT_W(4))  bus_s ();

  hazard_stall_ctrl #(.MD_LATENCY(4), .CNT_W(16)) u_dut (
    .clk (clk), .rst (rst), .bus (bus.slave)
  );
  hazard_stall_ctrl #(.MD_LATENCY(4), .CNT_W(4)) u_sat (
    .clk (clk), .rst (rst), .bus (bus_s.slave)
  );

  // Narrow instance mirrors the main instance's stimulus
  assign bus_s.id_rs        = bus.id_rs;
  assign bus_s.id_rt        = bus.id_rt;
  assign bus_s.id_uses_rt   = bus.id_uses_rt;
  assign bus_s.ex_mem_read  = bus.ex_mem_read;
  assign bus_s.ex_rt        = bus.ex_rt;
  assign bus_s.ex_md_start  = bus.ex_md_start;
  assign bus_s.branch_taken = bus.branch_taken;
  assign bus_s.mem_access   = bus.mem_access;
  assign bus_s.dmem_ready   = bus.dmem_ready;

  wire [8:0] ctl_obs = {bus.pc_write, bus.ifid_write, bus.ifid_flush,
                        bus.idex_write, bus.idex_flush, bus.exmem_write,
                        bus.exmem_flush, bus.md_busy, bus.md_done};
  wire [8:0] ctl_sat = {bus_s.pc_write, bus_s.ifid_write, bus_s.ifid_flush,
                        bus_s.idex_write, bus_s.idex_flush, bus_s.exmem_write,
                        bus_s.exmem_flush, bus_s.md_busy, bus_s.md_done};

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.id_rs        = 5'd0;
    bus.id_rt        = 5'd0;
    bus.id_uses_rt   = 1'b0;
    bus.ex_mem_read  = 1'b0;
    bus.ex_rt        = 5'd0;
    bus.ex_md_start  = 1'b0;
    bus.branch_taken = 1'b0;
    bus.mem_access   = 1'b0;
    bus.dmem_ready   = 1'b1;
  endtask

  // One cycle: inputs already driven; queue expectation, check at negedge,
  // then advance past the rising edge.
  task automatic step(input string tag, input logic [8:0] exp);
    logic [8:0] e;
    exp_q.push_back(exp);
    @(negedge clk);
    e = exp_q.pop_front();
    chk(tag, {23'd0, ctl_obs}, {23'd0, e});
    @(posedge clk);
    #1;
  endtask

  task automatic set_lu(input logic [4:0] rt, input logic [4:0] rs);
    bus.ex_mem_read = 1'b1;
    bus.ex_rt       = rt;
    bus.id_rs       = rs;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_ctl", {23'd0, ctl_obs}, {23'd0, C_ZERO});
    chk("rst_ctl_sat", {23'd0, ctl_sat}, {23'd0, C_ZERO});
    chk("rst_cnt", {16'd0, bus.stall_cnt}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    idle();
    @(posedge clk);
    #1;

    // T1: reset then idle
    do_reset();
    step("t1_idle0", C_RUN);
    step("t1_idle1", C_RUN);
    chk("t1_cnt", {16'd0, bus.stall_cnt}, 32'd0);

    // T2: load-use on rs, one bubble, then ex_rt==0 and rt-path variants
    set_lu(5'd5, 5'd5);
    step("t2_lu", C_LU);
    idle();
    step("t2_after", C_RUN);
    chk("t2_cnt", {16'd0, bus.stall_cnt}, 32'd1);
    set_lu(5'd0, 5'd0);
    step("t2_rt0", C_RUN);
    idle();
    bus.ex_mem_read = 1'b1;
    bus.ex_rt       = 5'd7;
    bus.id_rt       = 5'd7;
    bus.id_rs       = 5'd3;
    bus.id_uses_rt  = 1'b0;
    step("t2_rt_unused", C_RUN);
    bus.id_uses_rt  = 1'b1;
    step("t2_rt_used", C_LU);
    idle();
    step("t2_clear", C_RUN);
    chk("t2_cnt2", {16'd0, bus.stall_cnt}, 32'd2);

    // T3: mult/div occupies EX 4 cycles: 3 busy, release on the 4th
    bus.ex_md_start = 1'b1;
    step("t3_md0", C_MDB);
    bus.ex_md_start = 1'b0;
    chk("t3_state", {31'd0, bus.dbg_md_wait}, 32'd1);
    step("t3_md1", C_MDB);
    step("t3_md2", C_MDB);
    step("t3_rel", C_REL);
    step("t3_run", C_RUN);
    chk("t3_cnt", {16'd0, bus.stall_cnt}, 32'd5);

    // T4: branch in the 2nd MD_WAIT cycle aborts without md_done
    bus.ex_md_start = 1'b1;
    step("t4_md0", C_MDB);
    bus.ex_md_start = 1'b0;
    step("t4_md1", C_MDB);
    bus.branch_taken = 1'b1;
    step("t4_br", C_BR);
    bus.branch_taken = 1'b0;
    chk("t4_state", {31'd0, bus.dbg_md_wait}, 32'd0);
    step("t4_run0", C_RUN);
    step("t4_run1", C_RUN);
    chk("t4_cnt", {16'd0, bus.stall_cnt}, 32'd7);

    // T5: memory freeze during MD_WAIT with a pending branch
    bus.ex_md_start = 1'b1;
    step("t5_md0", C_MDB);
    bus.ex_md_start  = 1'b0;
    bus.mem_access   = 1'b1;
    bus.dmem_ready   = 1'b0;
    bus.branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("t5_frz", C_ZERO);
      chk("t5_mdcnt", {24'd0, bus.dbg_md_cnt}, 32'd2);
    end
    bus.dmem_ready = 1'b1;
    step("t5_br", C_BR);
    idle();
    step("t5_run", C_RUN);
    chk("t5_cnt", {16'd0, bus.stall_cnt}, 32'd11);

    // ex_md_start ignored in MD_WAIT; load-use applies on the release cycle
    bus.ex_md_start = 1'b1;
    step("md_start", C_MDB);
    step("md_restart_ign", C_MDB);
    bus.ex_md_start = 1'b0;
    step("md_wait", C_MDB);
    set_lu(5'd9, 5'd9);
    step("md_rel_lu", C_LUD);
    idle();
    step("md_run", C_RUN);

    // Same-cycle ex_md_start and branch: branch wins, mult/div not started
    bus.branch_taken = 1'b1;
    bus.ex_md_start  = 1'b1;
    step("br_md_ign", C_BR);
    idle();
    step("br_md_run", C_RUN);
    chk("cnt_15", {16'd0, bus.stall_cnt}, 32'd15);

    // T6: 20-cycle stall saturates the 4-bit counter, then async reset
    do_reset();
    set_lu(5'd4, 5'd4);
    for (int i = 0; i < 20; i++) step("t6_lu", C_LU);
    chk("t6_cnt16", {16'd0, bus.stall_cnt}, 32'd20);
    chk("t6_cnt4", {28'd0, bus_s.stall_cnt}, 32'd15);
    rst = 1'b0;
    #1;
    chk("t6_rst_ctl", {23'd0, ctl_obs}, {23'd0, C_ZERO});
    chk("t6_rst_sat", {23'd0, ctl_sat}, {23'd0, C_ZERO});
    chk("t6_rst_cnt", {28'd0, bus_s.stall_cnt}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle();
    step("t6_run", C_RUN);

    // Reset in mid MD_WAIT: back to RUN with no md_done pulse
    bus.ex_md_start = 1'b1;
    step("rmd_md0", C_MDB);
    bus.ex_md_start = 1'b0;
    rst = 1'b0;
    #1;
    chk("rmd_ctl", {23'd0, ctl_obs}, {23'd0, C_ZERO});
    chk("rmd_state", {31'd0, bus.dbg_md_wait}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step("rmd_run0", C_RUN);
    step("rmd_run1", C_RUN);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
